// File: rtl/vdp_pkg.sv
// vdp_pkg: shared constants for the VDP host read interface
package vdp_pkg;
  localparam int VDP_ADDR_WIDTH = 14;
  localparam int STAT_F = 7;
  localparam int STAT_5S = 6;
  localparam int STAT_C = 5;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ = 2'd1;
  localparam logic [1:0] S_REREQ = 2'd2;
endpackage

// File: rtl/vdp_status_reg.sv
// vdp_status_reg: F/5S/C/fifth_num status flags with read-clear and irq_n
module vdp_status_reg
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       coinc_set,
  input  logic       fifth_set,
  input  logic [4:0] fifth_in,
  input  logic       ie,
  output logic [7:0] status,
  output logic       irq_n
);
  logic f, s5, c;
  logic [4:0] fifth_num;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f <= 1'b0;
      s5 <= 1'b0;
      c <= 1'b0;
      fifth_num <= '0;
      irq_n <= 1'b1;
    end else begin
      f <= frame_tick | (f & ~clr);
      s5 <= fifth_set | (s5 & ~clr);
      c <= coinc_set | (c & ~clr);
      fifth_num <= (fifth_set & ~s5) ? fifth_in : fifth_num;
      irq_n <= ~(f & ie);
    end
  end
  always_comb begin
    status = {3'b000, fifth_num};
    status[STAT_F] = f;
    status[STAT_5S] = s5;
    status[STAT_C] = c;
  end
endmodule

// File: rtl/vdp_rd_ifce.sv
// vdp_rd_ifce: VDP CPU-port read side, status port and VRAM read-ahead buffer
module vdp_rd_ifce
  import vdp_pkg::*;
#(
  parameter int ADDR_WIDTH = VDP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_tick,
  input  logic                  port_sel,
  output logic [7:0]            dout,
  output logic                  toggle_clr,
  input  logic                  addr_ld,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  prefetch,
  output logic                  vram_req,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  input  logic                  vram_ack,
  input  logic [7:0]            vram_din,
  input  logic                  frame_tick,
  input  logic                  coinc_set,
  input  logic                  fifth_set,
  input  logic [4:0]            fifth_in,
  input  logic                  ie,
  output logic                  irq_n,
  output logic                  overrun
);
  logic [1:0] state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [7:0] buffer, status;
  logic data_rd, demand, kick, pend;
  assign data_rd = rd_tick & ~port_sel;
  assign demand = data_rd | (addr_ld & prefetch);
  assign kick = data_rd | addr_ld;
  assign addr_nxt = addr_ld ? addr_in : data_rd ? addr + ADDR_WIDTH'(1) : addr;
  vdp_status_reg u_status (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (rd_tick & port_sel),
    .frame_tick (frame_tick),
    .coinc_set  (coinc_set),
    .fifth_set  (fifth_set),
    .fifth_in   (fifth_in),
    .ie         (ie),
    .status     (status),
    .irq_n      (irq_n)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else state <= state_nxt;
  end
  // pend marks the one-clk request gap after a discarded ack; reissue follows
  always_comb begin
    state_nxt = state == S_IDLE ? ((demand | pend) ? S_REQ : S_IDLE) :
                state == S_REQ  ? (vram_ack ? (kick ? S_REQ : S_IDLE) : (kick ? S_REREQ : S_REQ)) :
                                  (vram_ack ? S_IDLE : S_REREQ);
  end
  always_comb vram_req = state != S_IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
      vram_addr <= '0;
      pend <= 1'b0;
      buffer <= '0;
      dout <= '0;
      toggle_clr <= 1'b0;
      overrun <= 1'b0;
    end else begin
      addr <= addr_nxt;
      vram_addr <= (state == S_IDLE || (state == S_REQ && vram_ack)) ? addr_nxt : vram_addr;
      pend <= state == S_REREQ && vram_ack;
      buffer <= (state == S_REQ && vram_ack) ? vram_din : buffer;
      dout <= rd_tick ? (port_sel ? status : buffer) : dout;
      toggle_clr <= rd_tick;
      overrun <= data_rd && state != S_IDLE;
    end
  end
endmodule

// File: tb/tb_vdp_rd_ifce.sv
// tb_vdp_rd_ifce: directed scoreboard bench for the VDP read interface
module tb_vdp_rd_ifce;
  logic clk = 1'b0, reset_n = 1'b0;
  logic rd_tick = 1'b0, port_sel = 1'b0, addr_ld = 1'b0, prefetch = 1'b0;
  logic [13:0] addr_in = '0;
  logic vram_ack = 1'b0;
  logic [7:0] vram_din = '0;
  logic frame_tick = 1'b0, coinc_set = 1'b0, fifth_set = 1'b0, ie = 1'b0;
  logic [4:0] fifth_in = '0;
  logic [7:0] dout;
  logic toggle_clr, vram_req, irq_n, overrun;
  logic [13:0] vram_addr;
  int checks = 0, failures = 0;
  logic [7:0] sb[$];

  vdp_rd_ifce dut (
    .clk(clk), .reset_n(reset_n), .rd_tick(rd_tick), .port_sel(port_sel),
    .dout(dout), .toggle_clr(toggle_clr), .addr_ld(addr_ld), .addr_in(addr_in),
    .prefetch(prefetch), .vram_req(vram_req), .vram_addr(vram_addr),
    .vram_ack(vram_ack), .vram_din(vram_din), .frame_tick(frame_tick),
    .coinc_set(coinc_set), .fifth_set(fifth_set), .fifth_in(fifth_in),
    .ie(ie), .irq_n(irq_n), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic p, input string tag);
    logic [7:0] e;
    rd_tick = 1'b1;
    port_sel = p;
    tick();
    rd_tick = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(tag, dout, e);
    end
    chk({tag, "_toggle_clr"}, toggle_clr, 1'b1);
  endtask

  task automatic ld(input logic [13:0] a, input logic pf);
    addr_in = a;
    prefetch = pf;
    addr_ld = 1'b1;
    tick();
    addr_ld = 1'b0;
    prefetch = 1'b0;
  endtask

  task automatic ack(input logic [7:0] d);
    vram_ack = 1'b1;
    vram_din = d;
    tick();
    vram_ack = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_dout", dout, 8'h00);
    chk("rst_req", vram_req, 1'b0);
    chk("rst_irq_n", irq_n, 1'b1);
    chk("rst_toggle", toggle_clr, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    tick();
    ld(14'h0100, 1'b1);
    chk("midfetch_req", vram_req, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_req", vram_req, 1'b0);
    chk("async_rst_irq", irq_n, 1'b1);
    chk("async_rst_dout", dout, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", vram_req, 1'b0);

    ld(14'h1234, 1'b1);
    chk("setup_req", vram_req, 1'b1);
    chk("setup_addr", vram_addr, 14'h1234);
    tick();
    tick();
    chk("setup_addr_stable", vram_addr, 14'h1234);
    ack(8'hA5);
    chk("setup_req_drop", vram_req, 1'b0);
    sb.push_back(8'hA5);
    rd(1'b0, "data_rd1");
    chk("refetch_req", vram_req, 1'b1);
    chk("refetch_addr", vram_addr, 14'h1235);
    ack(8'h5A);
    tick();
    chk("dout_held", dout, 8'hA5);
    chk("toggle_idle", toggle_clr, 1'b0);
    sb.push_back(8'h5A);
    rd(1'b0, "data_rd2");
    ack(8'h00);

    ld(14'h3FFF, 1'b1);
    chk("wrap_first_addr", vram_addr, 14'h3FFF);
    ack(8'h11);
    sb.push_back(8'h11);
    rd(1'b0, "wrap_rd1");
    chk("wrap_addr", vram_addr, 14'h0000);
    ack(8'h22);
    sb.push_back(8'h22);
    rd(1'b0, "wrap_rd2");
    chk("wrap_addr_next", vram_addr, 14'h0001);
    ack(8'h00);

    ld(14'h0200, 1'b1);
    ack(8'h33);
    sb.push_back(8'h33);
    rd(1'b0, "ovr_rd1");
    chk("ovr_first_none", overrun, 1'b0);
    chk("ovr_fetch_addr", vram_addr, 14'h0201);
    sb.push_back(8'h33);
    rd(1'b0, "ovr_rd2_stale");
    chk("ovr_pulse", overrun, 1'b1);
    chk("ovr_addr_stable", vram_addr, 14'h0201);
    tick();
    chk("ovr_single", overrun, 1'b0);
    chk("ovr_req_held", vram_req, 1'b1);
    tick();
    tick();
    ack(8'hEE);
    chk("rereq_gap", vram_req, 1'b0);
    tick();
    chk("rereq_req", vram_req, 1'b1);
    chk("rereq_addr", vram_addr, 14'h0202);
    ack(8'h44);
    sb.push_back(8'h44);
    rd(1'b0, "rereq_byte");

    ie = 1'b1;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
    chk("irq_assert", irq_n, 1'b0);
    fifth_in = 5'h0B;
    fifth_set = 1'b1;
    tick();
    fifth_in = 5'h07;
    tick();
    fifth_set = 1'b0;
    sb.push_back(8'hCB);
    rd(1'b1, "status_rd");
    tick();
    chk("irq_release", irq_n, 1'b1);
    sb.push_back(8'h0B);
    rd(1'b1, "status_cleared");
    frame_tick = 1'b1;
    tick();
    sb.push_back(8'h8B);
    rd(1'b1, "status_set_in_clear");
    frame_tick = 1'b0;
    sb.push_back(8'h8B);
    rd(1'b1, "status_f_kept");
    coinc_set = 1'b1;
    tick();
    coinc_set = 1'b0;
    sb.push_back(8'h2B);
    rd(1'b1, "status_c");
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
